// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and opcode classification helpers for the
// sequential ALU and its slice datapath.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBC  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_CP   = 5'd7;
  localparam logic [4:0] OP_INC  = 5'd8;
  localparam logic [4:0] OP_DEC  = 5'd9;
  localparam logic [4:0] OP_RLC  = 5'd10;
  localparam logic [4:0] OP_RRC  = 5'd11;
  localparam logic [4:0] OP_RL   = 5'd12;
  localparam logic [4:0] OP_RR   = 5'd13;
  localparam logic [4:0] OP_SLA  = 5'd14;
  localparam logic [4:0] OP_SRA  = 5'd15;
  localparam logic [4:0] OP_SWAP = 5'd16;
  localparam logic [4:0] OP_SRL  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops that walk the operand slice by slice through alu_slice
  function automatic logic is_sliced(input logic [4:0] op);
    return (op <= OP_DEC);
  endfunction

  function automatic logic is_sub(input logic [4:0] op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the decoder side and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_z;
  logic             out_n;
  logic             out_h;
  logic             out_c;

  modport master (
    output in_valid, in_op, in_a, in_b, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_z, out_n, out_h, out_c
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_z, out_n, out_h, out_c
  );
endinterface

// File: rtl/alu_slice.sv
// One SLICE_W-bit step of add/sub/logic with chained carry/borrow and the
// carry/borrow out of bit SLICE_W-5 (half flag source in the top slice).
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [4:0]         op,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] res,
  output logic               cout,
  output logic               half
);
  logic               sub;
  logic               arith;
  logic               half_raw;
  logic [SLICE_W:0]   wide;

  assign sub   = is_sub(op);
  assign arith = is_sliced(op) && !((op == OP_AND) || (op == OP_XOR) || (op == OP_OR));

  always_comb begin
    if (sub) wide = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, cin};
    else     wide = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  end

  // With 4-bit slices the half boundary is the slice boundary itself
  generate
    if (SLICE_W > 4) begin : g_half
      localparam int LW = SLICE_W - 4;
      logic [LW:0] low;
      always_comb begin
        if (sub) low = {1'b0, a[LW-1:0]} - {1'b0, b[LW-1:0]} - {{LW{1'b0}}, cin};
        else     low = {1'b0, a[LW-1:0]} + {1'b0, b[LW-1:0]} + {{LW{1'b0}}, cin};
      end
      assign half_raw = low[LW];
    end else begin : g_half_cin
      assign half_raw = cin;
    end
  endgenerate

  always_comb begin
    res  = wide[SLICE_W-1:0];
    cout = arith & wide[SLICE_W];
    half = arith & half_raw;
    case (op)
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU: arithmetic/logic walks SLICE_W-bit slices LSB
// first; rotates, shifts, SWAP and illegal ops finish in a single step.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state_q, state_d;
  logic [4:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic               cin_q, chain_q, zacc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               z_q, n_q, h_q, c_q;

  logic               accept, last, slice_step;
  logic [WIDTH-1:0]   b_eff;
  logic               seed;
  logic [4:0]         sl_op;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_res;
  logic               sl_cin, sl_cout, sl_half;
  logic [CNT_W-1:0]   idx;
  logic               cur_cin, zacc_in, sl_last, zero_so_far;
  logic [WIDTH-1:0]   one_res;
  logic               one_c;

  assign last = (cnt_q == CNT_W'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Slice 0 is computed in the accept cycle, so RUN covers slices 1..NSLICE-1
  always_comb begin
    state_d      = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = (is_sliced(bus.in_op) && (NSLICE > 1)) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    b_eff = bus.in_b;
    if ((bus.in_op == OP_INC) || (bus.in_op == OP_DEC)) b_eff = WIDTH'(1);
    seed = 1'b0;
    if ((bus.in_op == OP_ADC) || (bus.in_op == OP_SBC)) seed = bus.in_carry;

    sl_op   = bus.in_op;
    sl_a    = bus.in_a[SLICE_W-1:0];
    sl_b    = b_eff[SLICE_W-1:0];
    sl_cin  = seed;
    cur_cin = bus.in_carry;
    idx     = '0;
    zacc_in = 1'b1;
    sl_last = (NSLICE == 1);
    if (state_q == ST_RUN) begin
      sl_op   = op_q;
      sl_a    = a_q[int'(cnt_q)*SLICE_W +: SLICE_W];
      sl_b    = b_q[int'(cnt_q)*SLICE_W +: SLICE_W];
      sl_cin  = chain_q;
      cur_cin = cin_q;
      idx     = cnt_q;
      zacc_in = zacc_q;
      sl_last = last;
    end
  end

  assign slice_step  = (accept && is_sliced(bus.in_op)) || (state_q == ST_RUN);
  assign zero_so_far = zacc_in & (sl_res == '0);

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .op   (sl_op),
    .a    (sl_a),
    .b    (sl_b),
    .cin  (sl_cin),
    .res  (sl_res),
    .cout (sl_cout),
    .half (sl_half)
  );

  always_comb begin
    one_res = '0;
    one_c   = 1'b0;
    case (bus.in_op)
      OP_RLC: begin
        one_res = {bus.in_a[WIDTH-2:0], bus.in_a[WIDTH-1]};
        one_c   = bus.in_a[WIDTH-1];
      end
      OP_RRC: begin
        one_res = {bus.in_a[0], bus.in_a[WIDTH-1:1]};
        one_c   = bus.in_a[0];
      end
      OP_RL: begin
        one_res = {bus.in_a[WIDTH-2:0], bus.in_carry};
        one_c   = bus.in_a[WIDTH-1];
      end
      OP_RR: begin
        one_res = {bus.in_carry, bus.in_a[WIDTH-1:1]};
        one_c   = bus.in_a[0];
      end
      OP_SLA: begin
        one_res = {bus.in_a[WIDTH-2:0], 1'b0};
        one_c   = bus.in_a[WIDTH-1];
      end
      OP_SRA: begin
        one_res = {bus.in_a[WIDTH-1], bus.in_a[WIDTH-1:1]};
        one_c   = bus.in_a[0];
      end
      OP_SRL: begin
        one_res = {1'b0, bus.in_a[WIDTH-1:1]};
        one_c   = bus.in_a[0];
      end
      OP_SWAP: begin
        one_res = bus.in_a;
        for (int i = 0; i + 8 <= WIDTH; i += 8) begin
          one_res[i +: 4]   = bus.in_a[i+4 +: 4];
          one_res[i+4 +: 4] = bus.in_a[i +: 4];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cin_q   <= 1'b0;
      chain_q <= 1'b0;
      zacc_q  <= 1'b0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      h_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.in_op;
        a_q   <= bus.in_a;
        b_q   <= b_eff;
        cin_q <= bus.in_carry;
      end
      if (accept && !is_sliced(bus.in_op)) begin
        res_q <= one_res;
        z_q   <= (one_res == '0);
        n_q   <= 1'b0;
        h_q   <= 1'b0;
        c_q   <= one_c;
      end
      if (slice_step) begin
        // CP keeps A as the result while flags follow the subtraction
        res_q[int'(idx)*SLICE_W +: SLICE_W] <= (sl_op == OP_CP) ? sl_a : sl_res;
        chain_q <= sl_cout;
        zacc_q  <= zero_so_far;
        cnt_q   <= sl_last ? '0 : idx + CNT_W'(1);
        if (sl_last) begin
          z_q <= zero_so_far;
          n_q <= is_sub(sl_op);
          h_q <= (sl_op == OP_AND) | sl_half;
          c_q <= ((sl_op == OP_INC) || (sl_op == OP_DEC)) ? cur_cin : sl_cout;
        end
      end
    end
  end

  assign bus.out_result = res_q;
  assign bus.out_z      = z_q;
  assign bus.out_n      = n_q;
  assign bus.out_h      = h_q;
  assign bus.out_c      = c_q;

endmodule
